bldc_commutator: RTL

//  Parametrised 6-step BLDC commutation controller: successor to the purely combinational hall decoder.

---
 rtl/bldc_commutator.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/bldc_commutator.sv
`default_nettype none
// ============================================================================
// Module      : bldc_commutator
// Description : 6-step BLDC commutation with hall filtering, PWM chopping of
//               the high side, per-phase dead time and illegal-hall fault latch.
// Revision    : 1.0 - initial release
// ============================================================================
module bldc_commutator #(
  parameter int PWM_W    = 8,
  parameter int DEAD_CYC = 4,
  parameter int FILT_CYC = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic [PWM_W-1:0] duty,
  input  logic [2:0]       hall,
  input  logic             fault_clr,
  output logic [2:0]       gate_hi,
  output logic [2:0]       gate_lo,
  output logic [2:0]       sector,
  output logic             fault
);

  localparam int               c_FW      = $clog2(FILT_CYC + 1);
  localparam int               c_DW      = $clog2(DEAD_CYC + 1);
  localparam logic [c_FW-1:0]  c_FILT    = c_FW'(FILT_CYC);
  localparam logic [c_DW-1:0]  c_DEAD    = c_DW'(DEAD_CYC);
  localparam logic [PWM_W-1:0] c_CNT_MAX = '1;

  // Encodings differ by one bit from OFF so the gate decodes never glitch.
  typedef enum logic [1:0] {
    ST_OFF = 2'b00,
    ST_HI  = 2'b01,
    ST_LO  = 2'b10
  } phase_state_t;

  logic [2:0]       r_s1, r_s2, r_cand, r_hall_f;
  logic [c_FW-1:0]  r_fcnt, w_fcnt_nxt;
  logic             r_init, r_fault;
  logic [2:0]       r_sector, r_req_hi, r_req_lo;
  logic [PWM_W-1:0] r_cnt, r_duty_q;
  logic             w_hf_valid, w_fault_set, w_pwm_on;
  logic [2:0]       w_sec, w_fwd_hi, w_fwd_lo, w_dec_hi, w_dec_lo;

  // Count of consecutive edges on which the synchronised code was unchanged.
  always_comb begin
    w_fcnt_nxt = c_FW'(1);
    if (r_s2 == r_cand) begin
      w_fcnt_nxt = (r_fcnt == c_FILT) ? r_fcnt : r_fcnt + c_FW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_cand   <= '0;
      r_fcnt   <= '0;
      r_hall_f <= '0;
    end else begin
      r_s1   <= hall;
      r_s2   <= r_s1;
      r_cand <= r_s2;
      r_fcnt <= w_fcnt_nxt;
      if (w_fcnt_nxt == c_FILT) r_hall_f <= r_s2;
    end
  end

  assign w_hf_valid  = (r_hall_f != 3'b000) && (r_hall_f != 3'b111);
  // The 000 left by reset is not a sensor fault; only codes seen after a valid one are.
  assign w_fault_set = !w_hf_valid && !r_init;

  always_comb begin
    w_sec    = 3'd7;
    w_fwd_hi = 3'b000;
    w_fwd_lo = 3'b000;
    case (r_hall_f)
      3'b001: begin w_sec = 3'd0; w_fwd_hi = 3'b001; w_fwd_lo = 3'b010; end
      3'b011: begin w_sec = 3'd1; w_fwd_hi = 3'b001; w_fwd_lo = 3'b100; end
      3'b010: begin w_sec = 3'd2; w_fwd_hi = 3'b010; w_fwd_lo = 3'b100; end
      3'b110: begin w_sec = 3'd3; w_fwd_hi = 3'b010; w_fwd_lo = 3'b001; end
      3'b100: begin w_sec = 3'd4; w_fwd_hi = 3'b100; w_fwd_lo = 3'b001; end
      3'b101: begin w_sec = 3'd5; w_fwd_hi = 3'b100; w_fwd_lo = 3'b010; end
      default: ;
    endcase
  end

  assign w_dec_hi = dir ? w_fwd_lo : w_fwd_hi;
  assign w_dec_lo = dir ? w_fwd_hi : w_fwd_lo;
  assign w_pwm_on = (r_cnt < r_duty_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init   <= 1'b1;
      r_fault  <= 1'b0;
      r_sector <= 3'd7;
      r_req_hi <= '0;
      r_req_lo <= '0;
      r_cnt    <= '0;
      r_duty_q <= '0;
    end else begin
      if (w_hf_valid) r_init <= 1'b0;
      if (w_fault_set)                   r_fault <= 1'b1;
      else if (fault_clr && w_hf_valid)  r_fault <= 1'b0;
      r_sector <= w_sec;
      r_req_hi <= {3{en & ~r_fault & w_pwm_on}} & w_dec_hi;
      r_req_lo <= {3{en & ~r_fault}} & w_dec_lo;
      r_cnt    <= r_cnt + PWM_W'(1);
      // Duty only takes effect at a period boundary.
      if (r_cnt == c_CNT_MAX) r_duty_q <= duty;
    end
  end

  generate
    for (genvar p = 0; p < 3; p++) begin : g_phase
      phase_state_t    r_state, w_state_nxt;
      logic [c_DW-1:0] r_dcnt, w_dcnt_nxt;

      always_comb begin
        w_state_nxt = r_state;
        w_dcnt_nxt  = r_dcnt;
        case (r_state)
          ST_OFF: begin
            if (r_dcnt != c_DEAD) w_dcnt_nxt = r_dcnt + c_DW'(1);
            if (r_req_hi[p] && (r_dcnt == c_DEAD))      w_state_nxt = ST_HI;
            else if (r_req_lo[p] && (r_dcnt == c_DEAD)) w_state_nxt = ST_LO;
          end
          ST_HI: begin
            if (!r_req_hi[p]) begin
              w_state_nxt = ST_OFF;
              w_dcnt_nxt  = '0;
            end
          end
          ST_LO: begin
            if (!r_req_lo[p]) begin
              w_state_nxt = ST_OFF;
              w_dcnt_nxt  = '0;
            end
          end
          default: begin
            w_state_nxt = ST_OFF;
            w_dcnt_nxt  = '0;
          end
        endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_state <= ST_OFF;
          r_dcnt  <= c_DEAD;
        end else begin
          r_state <= w_state_nxt;
          r_dcnt  <= w_dcnt_nxt;
        end
      end

      assign gate_hi[p] = (r_state == ST_HI);
      assign gate_lo[p] = (r_state == ST_LO);
    end
  endgenerate

  assign sector = r_sector;
  assign fault  = r_fault;

endmodule
`default_nettype wire
